// File: rtl/en_reg4.sv
// en_reg4: parameterisable enabled holding register with synchronous clear.
// Q comes straight from the storage flops, so there is no combinational path
// from any input to Q. Each bit lives in its own cell; the top replicates that
// cell across WIDTH and gives each one its own bit of RESET_VALUE.

// One storage bit: clear takes priority over load, and the bit holds otherwise.
module en_reg4_bit #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  // Clear, load or hold, decided only at the rising edge.
  always_ff @(posedge clk) begin
    if (clr)     q <= RESET_BIT;
    else if (en) q <= d;
  end

endmodule

// Top level: WIDTH copies of the bit cell.
module en_reg4 #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  output logic [WIDTH-1:0] Q
);

  // CLR and EN fan out to every bit, so all bits change on the same edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    en_reg4_bit #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk (CLK),
      .clr (CLR),
      .en  (EN),
      .d   (D[i]),
      .q   (Q[i])
    );
  end

endmodule

// File: tb/tb_en_reg4.sv
// tb_en_reg4: directed bench for en_reg4. It covers clear, load, hold, reload,
// immunity to pulses between edges, clear-over-enable priority and
// follow-per-edge behaviour. Inputs change away from the rising edge, and Q is
// sampled 1 ns after each edge.
module tb_en_reg4;

  logic       CLK;
  logic       CLR;
  logic [3:0] D;
  logic       EN;
  logic [3:0] Q;

  int n_cmp = 0;
  int n_err = 0;

  en_reg4 #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0000)
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .D   (D),
    .EN  (EN),
    .Q   (Q)
  );

  // 10 ns clock period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare Q against a hand-computed value.
  task automatic check(input string tag, input logic [3:0] exp);
    n_cmp++;
    assert (Q === exp)
    else begin
      n_err++;
      $error("FAIL %s: Q=%b expected %b", tag, Q, exp);
    end
  endtask

  // Advance through one rising edge, then settle before sampling.
  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  // Directed stimulus.
  initial begin
    CLR = 1'b0;
    EN  = 1'b0;
    D   = 4'b0000;
    #2;

    // Clear wins over a pending load.
    CLR = 1'b1; D = 4'b1010; EN = 1'b1;
    edge_step(); check("clear", 4'b0000);
    CLR = 1'b0;
    edge_step(); check("clear_release", 4'b1010);

    // Load.
    D = 4'b1110; EN = 1'b1;
    edge_step(); check("load", 4'b1110);

    // Hold while D changes.
    EN = 1'b0; D = 4'b1011;
    edge_step(); check("hold_1", 4'b1110);
    D = 4'b0011;
    edge_step(); check("hold_2", 4'b1110);
    D = 4'b0100;
    edge_step(); check("hold_3", 4'b1110);

    // Reload for one edge, then hold again.
    EN = 1'b1;
    edge_step(); check("reload", 4'b0100);
    D = 4'b0000; EN = 1'b0;
    edge_step(); check("reload_hold", 4'b0100);

    // Pulses strictly between edges must have no effect.
    D = 4'b1111;
    #1 CLR = 1'b1;
    #2 CLR = 1'b0;
    check("glitch_clr_mid", 4'b0100);
    #1 EN = 1'b1;
    #2 EN = 1'b0;
    check("glitch_en_mid", 4'b0100);
    edge_step(); check("glitch_edge", 4'b0100);

    // CLR and EN high together: clear wins. Clear held over two edges.
    CLR = 1'b1; EN = 1'b1; D = 4'b1111;
    edge_step(); check("prio_clr_en", 4'b0000);
    edge_step(); check("clr_held", 4'b0000);

    // Normal operation resumes; EN high continuously, Q follows D.
    CLR = 1'b0; D = 4'b0001;
    edge_step(); check("follow_1", 4'b0001);
    D = 4'b0010;
    check("follow_pre_edge", 4'b0001);
    edge_step(); check("follow_2", 4'b0010);
    D = 4'b0011;
    edge_step(); check("follow_3", 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/en_reg4.md
Name: en_reg4

Overview:
- 4-bit (parameterisable) D-register with synchronous clear and load enable.
- Used as a general datapath holding register: it captures D only when EN is asserted and otherwise holds its contents.
- Single clock domain, no internal state beyond the stored word.

Parameters:
- WIDTH, 4, data width of D and Q in bits.
- RESET_VALUE, 0 (WIDTH bits), value loaded into Q when CLR is sampled high.

Ports:
- CLK  input  1  clock; all state changes on the rising edge only.
- CLR  input  1  clear; synchronous, active-high.
- D  input  WIDTH  data to be captured.
- EN  input  1  load enable, active-high.
- Q  output  WIDTH  registered data; driven directly from the storage flops with no combinational path from any input.

Behaviour:
- Single clock CLK; reset CLR is synchronous and active-high. CLR is sampled only at the rising edge of CLK.
- On each rising edge of CLK, in priority order:
  - CLR=1: Q <= RESET_VALUE, regardless of EN and D.
  - CLR=0, EN=1: Q <= D.
  - CLR=0, EN=0: Q holds its previous value.
- Latency: a D value sampled with EN=1 appears on Q after the same rising edge. There is no additional pipeline stage.
- Changes on D or EN between rising edges have no effect on Q.
- A CLR pulse that does not span a rising edge has no effect. There is no asynchronous clear path.
- Q value at power-up, before the first clearing edge, is undefined. Users must apply CLR for at least one rising edge before relying on Q.
- CLR and EN both high at the same edge: clear wins, and Q = RESET_VALUE.
- CLR held high for multiple edges: Q stays RESET_VALUE. On the first edge with CLR=0, normal EN/D behaviour resumes.
- EN held high continuously: Q follows D, one sample per edge.
- No X-propagation masking: an X on EN with CLR=0 may produce an X on Q, and the bench must not drive X on EN.
- Width rule: D and Q are exactly WIDTH bits, with no truncation or extension.

Test Plan:
- Clear: drive CLR=1 over one rising edge with D=4'b1010 and EN=1 -> Q=4'b0000 after that edge. Release CLR -> at the next edge Q=4'b1010.
- Load: CLR=0, D=4'b1110, EN=1 at an edge -> Q=4'b1110.
- Hold: EN=0, then D=4'b1011, 4'b0011 and 4'b0100 on three successive edges -> Q remains 4'b1110 throughout.
- Reload: with D=4'b0100 held, raise EN=1 for one edge -> Q=4'b0100. Then set D=0 and EN=0 -> Q stays 4'b0100.
- Glitch immunity: pulse CLR high, and separately pulse EN high, each strictly between rising edges, with D=4'b1111 -> Q unchanged at the next edge.
- Priority: CLR=1 and EN=1 with D=4'b1111 on the same edge -> Q=4'b0000. With EN=1 continuously and D stepping 1,2,3 -> Q follows 1,2,3, each one edge after D is presented.
